// File: rtl/dfi_cmd_monitor_if.sv
// rtl/dfi_cmd_monitor_if.sv - DFI command pins (4 phases) and record readout stream
interface dfi_cmd_monitor_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int TS_WIDTH   = 16
);
   localparam int DW = TS_WIDTH + 8 + ADDR_WIDTH;

   logic                  dfi_p0_cs_n, dfi_p0_ras_n, dfi_p0_cas_n, dfi_p0_we_n;
   logic                  dfi_p1_cs_n, dfi_p1_ras_n, dfi_p1_cas_n, dfi_p1_we_n;
   logic                  dfi_p2_cs_n, dfi_p2_ras_n, dfi_p2_cas_n, dfi_p2_we_n;
   logic                  dfi_p3_cs_n, dfi_p3_ras_n, dfi_p3_cas_n, dfi_p3_we_n;
   logic [2:0]            dfi_p0_bank, dfi_p1_bank, dfi_p2_bank, dfi_p3_bank;
   logic [ADDR_WIDTH-1:0] dfi_p0_address, dfi_p1_address, dfi_p2_address, dfi_p3_address;

   logic                  out_valid;
   logic                  out_ready;
   logic [DW-1:0]         out_data;

   modport master (
      output dfi_p0_cs_n, dfi_p0_ras_n, dfi_p0_cas_n, dfi_p0_we_n,
      output dfi_p1_cs_n, dfi_p1_ras_n, dfi_p1_cas_n, dfi_p1_we_n,
      output dfi_p2_cs_n, dfi_p2_ras_n, dfi_p2_cas_n, dfi_p2_we_n,
      output dfi_p3_cs_n, dfi_p3_ras_n, dfi_p3_cas_n, dfi_p3_we_n,
      output dfi_p0_bank, dfi_p1_bank, dfi_p2_bank, dfi_p3_bank,
      output dfi_p0_address, dfi_p1_address, dfi_p2_address, dfi_p3_address,
      output out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  dfi_p0_cs_n, dfi_p0_ras_n, dfi_p0_cas_n, dfi_p0_we_n,
      input  dfi_p1_cs_n, dfi_p1_ras_n, dfi_p1_cas_n, dfi_p1_we_n,
      input  dfi_p2_cs_n, dfi_p2_ras_n, dfi_p2_cas_n, dfi_p2_we_n,
      input  dfi_p3_cs_n, dfi_p3_ras_n, dfi_p3_cas_n, dfi_p3_we_n,
      input  dfi_p0_bank, dfi_p1_bank, dfi_p2_bank, dfi_p3_bank,
      input  dfi_p0_address, dfi_p1_address, dfi_p2_address, dfi_p3_address,
      input  out_ready,
      output out_valid, out_data
   );
endinterface

// File: rtl/dfi_cmd_monitor.sv
// rtl/dfi_cmd_monitor.sv - passive DFI command decoder with timestamped multi-write record FIFO
module dfi_cmd_monitor #(
   parameter int         ADDR_WIDTH   = 16,
   parameter int         DEPTH        = 16,
   parameter int         TS_WIDTH     = 16,
   parameter logic [7:0] CAPTURE_MASK = 8'hFF
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     en_i,
   input  logic                     clear_i,
   dfi_cmd_monitor_if.slave         bus,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overflow_o,
   output logic [15:0]              drop_cnt_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int DW = TS_WIDTH + 8 + ADDR_WIDTH;

   typedef enum logic {IDLE, CAPTURE} state_t;

   state_t                state_q;
   logic [TS_WIDTH-1:0]   ts_q, ts_d;
   logic [LW-1:0]         wr_ptr_q, rd_ptr_q, level_q, level_d, free;
   logic                  overflow_q;
   logic [15:0]           drop_cnt_q;
   logic [16:0]           drop_sum;
   logic [DW-1:0]         mem_q [DEPTH];

   logic [3:0]            cs_n;
   logic [2:0]            rcw  [4];
   logic [2:0]            bank [4];
   logic [ADDR_WIDTH-1:0] addr [4];
   logic [2:0]            code [4];
   logic [2:0]            offs [4];
   logic [PW-1:0]         widx [4];
   logic [DW-1:0]         rec  [4];
   logic [3:0]            vld;
   logic [2:0]            cnt;
   logic                  push, pop;

   always_comb begin
      cs_n    = {bus.dfi_p3_cs_n, bus.dfi_p2_cs_n, bus.dfi_p1_cs_n, bus.dfi_p0_cs_n};
      rcw[0]  = {bus.dfi_p0_ras_n, bus.dfi_p0_cas_n, bus.dfi_p0_we_n};
      rcw[1]  = {bus.dfi_p1_ras_n, bus.dfi_p1_cas_n, bus.dfi_p1_we_n};
      rcw[2]  = {bus.dfi_p2_ras_n, bus.dfi_p2_cas_n, bus.dfi_p2_we_n};
      rcw[3]  = {bus.dfi_p3_ras_n, bus.dfi_p3_cas_n, bus.dfi_p3_we_n};
      bank[0] = bus.dfi_p0_bank;
      bank[1] = bus.dfi_p1_bank;
      bank[2] = bus.dfi_p2_bank;
      bank[3] = bus.dfi_p3_bank;
      addr[0] = bus.dfi_p0_address;
      addr[1] = bus.dfi_p1_address;
      addr[2] = bus.dfi_p2_address;
      addr[3] = bus.dfi_p3_address;
   end

   // Timestamp restarts at 0 on the first enabled cycle after IDLE; all phases share it.
   always_comb begin
      ts_d = (state_q == CAPTURE) ? ts_q + TS_WIDTH'(1) : '0;
      cnt  = '0;
      vld  = '0;
      for (int p = 0; p < 4; p++) begin
         case (rcw[p])
            3'b011:  code[p] = 3'd1;
            3'b010:  code[p] = 3'd2;
            3'b101:  code[p] = 3'd3;
            3'b100:  code[p] = 3'd4;
            3'b001:  code[p] = 3'd5;
            3'b000:  code[p] = 3'd6;
            3'b110:  code[p] = 3'd7;
            default: code[p] = 3'd0;
         endcase
         vld[p]  = en_i && !cs_n[p] && (code[p] != 3'd0) && CAPTURE_MASK[code[p]];
         offs[p] = cnt;
         widx[p] = wr_ptr_q[PW-1:0] + PW'(offs[p]);
         rec[p]  = {ts_d, 2'(p), code[p], bank[p], addr[p]};
         cnt     = cnt + {2'b00, vld[p]};
      end
   end

   // Space check uses the registered level; a same-cycle pop does not make room.
   always_comb begin
      free     = LW'(DEPTH) - level_q;
      push     = (cnt != 3'd0) && (LW'(cnt) <= free);
      pop      = bus.out_valid && bus.out_ready;
      level_d  = level_q + (push ? LW'(cnt) : '0) - LW'(pop);
      drop_sum = {1'b0, drop_cnt_q} + 17'(cnt);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_q    <= IDLE;
         ts_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         if (en_i) begin
            state_q <= CAPTURE;
            ts_q    <= ts_d;
         end else begin
            state_q <= IDLE;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + LW'(cnt);
         end else if (cnt != 3'd0) begin
            overflow_q <= 1'b1;
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + LW'(1);
         end
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && !clear_i && push) begin
         for (int p = 0; p < 4; p++) begin
            if (vld[p]) begin
               mem_q[widx[p]] <= rec[p];
            end
         end
      end
   end

   assign bus.out_valid = (level_q != '0);
   assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q[PW-1:0]] : '0;
   assign level_o       = level_q;
   assign overflow_o    = overflow_q;
   assign drop_cnt_o    = drop_cnt_q;
endmodule

// File: tb/tb_dfi_cmd_monitor.sv
// tb/tb_dfi_cmd_monitor.sv - scoreboard bench for dfi_cmd_monitor (full mask and 8'h06 mask instances)
module tb_dfi_cmd_monitor;
   localparam int AW    = 16;
   localparam int TW    = 16;
   localparam int DEPTH = 16;
   localparam int DW    = TW + 8 + AW;

   typedef logic [DW-1:0] rec_t;

   localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, PRE = 3'd2, RD = 3'd3,
                          WR = 3'd4, REF = 3'd5, MRS = 3'd6, ZQ = 3'd7;

   logic clk = 1'b0;
   logic rst, en, clear, rdy;
   logic          ph_cs   [4];
   logic [2:0]    ph_code [4];
   logic [2:0]    ph_bank [4];
   logic [AW-1:0] ph_addr [4];

   logic [4:0]  level_f, level_m;
   logic        ovf_f, ovf_m;
   logic [15:0] drop_f, drop_m;

   always #5 clk = ~clk;

   dfi_cmd_monitor_if #(.ADDR_WIDTH(AW), .TS_WIDTH(TW)) bus_f ();
   dfi_cmd_monitor_if #(.ADDR_WIDTH(AW), .TS_WIDTH(TW)) bus_m ();

   dfi_cmd_monitor #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .TS_WIDTH(TW), .CAPTURE_MASK(8'hFF)) dut_f (
      .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear), .bus(bus_f),
      .level_o(level_f), .overflow_o(ovf_f), .drop_cnt_o(drop_f));

   dfi_cmd_monitor #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .TS_WIDTH(TW), .CAPTURE_MASK(8'h06)) dut_m (
      .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear), .bus(bus_m),
      .level_o(level_m), .overflow_o(ovf_m), .drop_cnt_o(drop_m));

   function automatic logic [2:0] pins(input logic [2:0] c);
      case (c)
         ACT:     return 3'b011;
         PRE:     return 3'b010;
         RD:      return 3'b101;
         WR:      return 3'b100;
         REF:     return 3'b001;
         MRS:     return 3'b000;
         ZQ:      return 3'b110;
         default: return 3'b111;
      endcase
   endfunction

   always_comb begin
      bus_f.dfi_p0_cs_n = ph_cs[0];
      bus_f.dfi_p1_cs_n = ph_cs[1];
      bus_f.dfi_p2_cs_n = ph_cs[2];
      bus_f.dfi_p3_cs_n = ph_cs[3];
      {bus_f.dfi_p0_ras_n, bus_f.dfi_p0_cas_n, bus_f.dfi_p0_we_n} = pins(ph_code[0]);
      {bus_f.dfi_p1_ras_n, bus_f.dfi_p1_cas_n, bus_f.dfi_p1_we_n} = pins(ph_code[1]);
      {bus_f.dfi_p2_ras_n, bus_f.dfi_p2_cas_n, bus_f.dfi_p2_we_n} = pins(ph_code[2]);
      {bus_f.dfi_p3_ras_n, bus_f.dfi_p3_cas_n, bus_f.dfi_p3_we_n} = pins(ph_code[3]);
      bus_f.dfi_p0_bank = ph_bank[0];
      bus_f.dfi_p1_bank = ph_bank[1];
      bus_f.dfi_p2_bank = ph_bank[2];
      bus_f.dfi_p3_bank = ph_bank[3];
      bus_f.dfi_p0_address = ph_addr[0];
      bus_f.dfi_p1_address = ph_addr[1];
      bus_f.dfi_p2_address = ph_addr[2];
      bus_f.dfi_p3_address = ph_addr[3];
      bus_f.out_ready = rdy;
   end

   always_comb begin
      bus_m.dfi_p0_cs_n = ph_cs[0];
      bus_m.dfi_p1_cs_n = ph_cs[1];
      bus_m.dfi_p2_cs_n = ph_cs[2];
      bus_m.dfi_p3_cs_n = ph_cs[3];
      {bus_m.dfi_p0_ras_n, bus_m.dfi_p0_cas_n, bus_m.dfi_p0_we_n} = pins(ph_code[0]);
      {bus_m.dfi_p1_ras_n, bus_m.dfi_p1_cas_n, bus_m.dfi_p1_we_n} = pins(ph_code[1]);
      {bus_m.dfi_p2_ras_n, bus_m.dfi_p2_cas_n, bus_m.dfi_p2_we_n} = pins(ph_code[2]);
      {bus_m.dfi_p3_ras_n, bus_m.dfi_p3_cas_n, bus_m.dfi_p3_we_n} = pins(ph_code[3]);
      bus_m.dfi_p0_bank = ph_bank[0];
      bus_m.dfi_p1_bank = ph_bank[1];
      bus_m.dfi_p2_bank = ph_bank[2];
      bus_m.dfi_p3_bank = ph_bank[3];
      bus_m.dfi_p0_address = ph_addr[0];
      bus_m.dfi_p1_address = ph_addr[1];
      bus_m.dfi_p2_address = ph_addr[2];
      bus_m.dfi_p3_address = ph_addr[3];
      bus_m.out_ready = rdy;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   rec_t          q0[$];
   rec_t          q1[$];
   logic          m_ovf  [2];
   int            m_drop [2];
   logic [TW-1:0] m_ts;
   logic          running;

   task automatic nop_all();
      for (int p = 0; p < 4; p++) begin
         ph_cs[p] = 1'b0; ph_code[p] = NOP; ph_bank[p] = '0; ph_addr[p] = '0;
      end
   endtask

   task automatic cmd(input int p, input logic [2:0] c, input logic [2:0] b, input logic [AW-1:0] a);
      ph_cs[p] = 1'b0; ph_code[p] = c; ph_bank[p] = b; ph_addr[p] = a;
   endtask

   task automatic check_outputs();
      chk("f_valid", bus_f.out_valid, q0.size() != 0);
      chk("f_level", level_f, q0.size());
      chk("f_ovf",   ovf_f, m_ovf[0]);
      chk("f_drop",  drop_f, m_drop[0]);
      if (q0.size() != 0) chk("f_data", bus_f.out_data, q0[0]);
      chk("m_valid", bus_m.out_valid, q1.size() != 0);
      chk("m_level", level_m, q1.size());
      chk("m_ovf",   ovf_m, m_ovf[1]);
      chk("m_drop",  drop_m, m_drop[1]);
      if (q1.size() != 0) chk("m_data", bus_m.out_data, q1[0]);
   endtask

   // Apply this cycle's inputs to the reference queues, clock once, then compare.
   task automatic step();
      rec_t          recs[$];
      logic [7:0]    mask;
      logic [TW-1:0] ts_use;
      int            sz;
      ts_use = running ? m_ts + 16'd1 : '0;
      for (int i = 0; i < 2; i++) begin
         mask = (i == 0) ? 8'hFF : 8'h06;
         recs = {};
         for (int p = 0; p < 4; p++)
            if (en && !ph_cs[p] && ph_code[p] != NOP && mask[ph_code[p]])
               recs.push_back({ts_use, 2'(p), ph_code[p], ph_bank[p], ph_addr[p]});
         sz = (i == 0) ? q0.size() : q1.size();
         if (rst || clear) begin
            if (i == 0) q0.delete(); else q1.delete();
            m_ovf[i] = 1'b0; m_drop[i] = 0;
         end else begin
            if (sz != 0 && rdy) begin
               if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (recs.size() <= DEPTH - sz) begin
               foreach (recs[k]) if (i == 0) q0.push_back(recs[k]); else q1.push_back(recs[k]);
            end else begin
               m_ovf[i]  = 1'b1;
               m_drop[i] = (m_drop[i] + recs.size() > 65535) ? 65535 : m_drop[i] + recs.size();
            end
         end
      end
      if (rst || clear) running = 1'b0;
      else if (en) begin running = 1'b1; m_ts = ts_use; end
      else running = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic quad(input logic [2:0] b);
      cmd(0, ACT, b, 16'($urandom)); cmd(1, RD, b, 16'($urandom));
      cmd(2, PRE, b, 16'($urandom)); cmd(3, REF, b, 16'($urandom));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; clear = 1'b0; rdy = 1'b0;
      nop_all();
      running = 1'b0; m_ts = '0;
      m_ovf[0] = 1'b0; m_ovf[1] = 1'b0; m_drop[0] = 0; m_drop[1] = 0;
      @(negedge clk);
      step(); step();
      chk("rst_data", bus_f.out_data, '0);
      chk("rst_level", level_f, 0);
      rst = 1'b0;
      step();

      // single ACT at ts=5
      en = 1'b1;
      repeat (5) step();
      cmd(2, ACT, 3'd0, 16'h0123);
      step();
      nop_all();
      chk("t1_rec", bus_f.out_data, {16'd5, 2'd2, ACT, 3'd0, 16'h0123});
      chk("t1_level", level_f, 1);
      rdy = 1'b1;
      step();
      rdy = 1'b0;

      // PRE p0 + ACT p3 in one cycle, ts=7
      cmd(0, PRE, 3'd1, 16'h0040);
      cmd(3, ACT, 3'd2, 16'h00A0);
      step();
      nop_all();
      chk("t2_level", level_f, 2);
      chk("t2_first", bus_f.out_data, {16'd7, 2'd0, PRE, 3'd1, 16'h0040});
      rdy = 1'b1;
      step();
      chk("t2_second", bus_f.out_data, {16'd7, 2'd3, ACT, 3'd2, 16'h00A0});
      step();
      rdy = 1'b0;

      // fill to DEPTH, then overflow cycle
      for (int c = 0; c < 4; c++) begin quad(3'(c)); step(); end
      chk("t3_full", level_f, 16);
      chk("t3_noovf", ovf_f, 1'b0);
      chk("t3_mask_level", level_m, 8);
      quad(3'd7); step();
      chk("t3_ovf", ovf_f, 1'b1);
      chk("t3_drop", drop_f, 4);
      chk("t3_keep", level_f, 16);

      // clear with capture and pop pending, then level 14 + pop + 4 commands
      rdy = 1'b1; clear = 1'b1; step();
      clear = 1'b0; rdy = 1'b0;
      chk("clr_level", level_f, 0);
      chk("clr_ovf", ovf_f, 1'b0);
      for (int c = 0; c < 3; c++) begin quad(3'(c)); step(); end
      nop_all(); cmd(0, WR, 3'd4, 16'h1111); cmd(1, MRS, 3'd5, 16'h2222); step();
      chk("t4_pre", level_f, 14);
      rdy = 1'b1; quad(3'd6); step();
      rdy = 1'b0; nop_all();
      chk("t4_level", level_f, 13);
      chk("t4_drop", drop_f, 4);

      // mask 8'h06 instance: ACT/PRE only, NOP and deselect ignored
      clear = 1'b1; step(); clear = 1'b0;
      quad(3'd1); step();
      nop_all();
      ph_cs[0] = 1'b1; ph_code[0] = ACT; ph_code[1] = NOP; step();
      nop_all();
      chk("t5_mask_level", level_m, 2);
      chk("t5_full_level", level_f, 4);

      // reset mid-drain, then first record after reset carries ts=0
      for (int c = 0; c < 3; c++) begin quad(3'(c)); step(); end
      rdy = 1'b1; rst = 1'b1; step();
      rst = 1'b0; rdy = 1'b0; nop_all();
      chk("t6_valid", bus_f.out_valid, 1'b0);
      chk("t6_level", level_f, 0);
      chk("t6_ovf", ovf_f, 1'b0);
      cmd(1, WR, 3'd3, 16'hBEEF); step();
      nop_all();
      chk("t6_ts0", bus_f.out_data, {16'd0, 2'd1, WR, 3'd3, 16'hBEEF});

      // random traffic
      for (int n = 0; n < 300; n++) begin
         en    = ($urandom_range(0, 9) != 0);
         rdy   = ($urandom_range(0, 2) == 0);
         clear = ($urandom_range(0, 49) == 0);
         for (int p = 0; p < 4; p++)
            cmd(p, 3'($urandom_range(0, 7)), 3'($urandom), 16'($urandom));
         for (int p = 0; p < 4; p++) ph_cs[p] = ($urandom_range(0, 4) == 0);
         step();
      end
      clear = 1'b0; nop_all(); en = 1'b0; rdy = 1'b1;
      repeat (20) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
